time_set_ctrl: RTL and testbench
================================

Name: time_set_ctrl

Overview:
- Front-end controller for the static time register (ap/hour/min with per-field increment/decrement strobes).
- Conditions three raw buttons (mode, up, down) and runs a field-select state machine.
- Issues single-cycle increment/decrement strobes to the selected field, with auto-repeat on hold.
- Returns to RUN after an inactivity timeout; exports the selected field so the display can blink it.

Parameters:
DEB_CYCLES, 4, consecutive stable samples needed to accept a button level change (>=2)
HOLD_CYCLES, 500, cycles an up/down press must be held before auto-repeat starts
REPEAT_CYCLES, 100, cycles between auto-repeat strobes (>=3)
TIMEOUT_CYCLES, 10000, idle cycles in any SET state before returning to RUN
CNT_W, 16, width of internal counters; must hold max(HOLD_CYCLES, TIMEOUT_CYCLES)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
btn_mode  in  1  raw mode button, active-high, asynchronous to clk
btn_up  in  1  raw up button, active-high, asynchronous to clk
btn_down  in  1  raw down button, active-high, asynchronous to clk
i_a  out  1  AM/PM toggle strobe, one cycle
i_h  out  1  hour increment strobe, one cycle
i_m  out  1  minute increment strobe, one cycle
d_h  out  1  hour decrement strobe, one cycle
d_m  out  1  minute decrement strobe, one cycle
sel  out  2  selected field: 0=none (RUN), 1=hour, 2=min, 3=ap
editing  out  1  high in any SET state

Behaviour:
- Reset (rst=1, async): state=RUN, sel=0, editing=0, all strobes 0, all sync flops, debouncers and counters cleared, debounced levels=0.
- Input path: each button passes through a 2-FF synchronizer, then a debouncer. The debounced level changes only after DEB_CYCLES consecutive identical synchronized samples. A press edge is a debounced 0->1 transition.
- FSM transitions on a mode press edge:
  - RUN -> SET_HOUR -> SET_MIN -> SET_AP -> RUN.
  - sel/editing are registered and follow the state in the same cycle the state updates.
- In RUN, up/down are ignored and no strobes are issued.
- Up press edge: strobe fires the next cycle, one cycle wide.
  - SET_HOUR: i_h. SET_MIN: i_m. SET_AP: i_a.
- Down press edge: SET_HOUR: d_h. SET_MIN: d_m. SET_AP: i_a, since AM/PM has no decrement and toggling is its own inverse.
- Auto-repeat (hour/min states only; never in SET_AP):
  - While the same direction stays held, the hold counter counts from the press edge.
  - At HOLD_CYCLES the first repeat strobe fires, then one every REPEAT_CYCLES until release.
- Strobe spacing: at most one strobe asserted in any cycle; consecutive strobes are separated by >=2 low cycles. The downstream register acts on strobe fall, so each strobe yields exactly one step.
- Up and down both debounced-high:
  - No strobe is issued and the repeat counter is cleared.
  - After one button is released, the remaining one needs a fresh press edge.
- Mode press while up/down is held:
  - Mode wins: state advances, repeat is cancelled, no strobe in that cycle.
  - The held button needs release and re-press to act in the new state.
- Timeout:
  - The idle counter clears on any debounced press edge or active repeat and counts otherwise in SET states.
  - At TIMEOUT_CYCLES, state goes to RUN and sel goes to 0; no strobe is issued.
- Counters saturate; they never wrap.
- Reset asserted mid-operation: all outputs drop to reset values immediately, including any strobe in progress.

Test Plan:
- DEB_CYCLES=4: pulse btn_mode high for 2 cycles -> no state change, sel stays 0. Hold 10 cycles -> sel=1, editing=1.
- In SET_HOUR, one short up press -> exactly one i_h pulse, 1 cycle wide. Down press -> one d_h pulse. No other strobes.
- HOLD_CYCLES=20, REPEAT_CYCLES=5: hold up in SET_MIN for 45 cycles past the press edge -> i_m at edge+1, then at hold 20, 25, 30, 35, 40 (6 pulses total). Release -> none further.
- In SET_AP, hold down for 100 cycles -> exactly one i_a pulse. Then press mode -> sel=0, editing=0.
- Up held, then down also pressed -> strobes stop. Release down with up still held -> no strobe until up is released and re-pressed.
- TIMEOUT_CYCLES=50: enter SET_MIN, stay idle -> state=RUN and sel=0 at 50 idle cycles. Assert rst mid-repeat -> strobes and sel go to 0 asynchronously.

Source files
------------

// File: rtl/time_set_ctrl_if.sv
// Button inputs and field-edit outputs of the time-set front end.
// The bench (master) drives raw buttons; the controller (slave) drives
// the increment/decrement strobes and the field-select status.
interface time_set_ctrl_if;
  logic       btn_mode;
  logic       btn_up;
  logic       btn_down;
  logic       i_a;
  logic       i_h;
  logic       i_m;
  logic       d_h;
  logic       d_m;
  logic [1:0] sel;
  logic       editing;

  modport master (
    output btn_mode, btn_up, btn_down,
    input  i_a, i_h, i_m, d_h, d_m, sel, editing
  );

  modport slave (
    input  btn_mode, btn_up, btn_down,
    output i_a, i_h, i_m, d_h, d_m, sel, editing
  );
endinterface

// File: rtl/time_set_ctrl.sv
// Time-set front end: synchronizes and debounces the mode/up/down buttons,
// steps through the hour/min/AM-PM fields on mode presses, and issues
// one-cycle increment/decrement strobes with auto-repeat while held.
// Falls back to RUN after a period with no button activity.
module time_set_ctrl #(
  parameter int DEB_CYCLES     = 4,
  parameter int HOLD_CYCLES    = 500,
  parameter int REPEAT_CYCLES  = 100,
  parameter int TIMEOUT_CYCLES = 10000,
  parameter int CNT_W          = 16
) (
  input logic            clk,
  input logic            rst,
  time_set_ctrl_if.slave bus
);

  // sel is the state encoding itself, so RUN must stay 0
  typedef enum logic [1:0] {
    RUN      = 2'd0,
    SET_HOUR = 2'd1,
    SET_MIN  = 2'd2,
    SET_AP   = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    REP_NONE = 2'd0,
    REP_UP   = 2'd1,
    REP_DOWN = 2'd2
  } rep_t;

  localparam int DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [DW-1:0]    DEB_LAST  = DW'(DEB_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);
  localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  // Button index: 0 = mode, 1 = up, 2 = down
  logic [2:0]    sync1;
  logic [2:0]    sync2;
  logic [2:0]    level;
  logic [2:0]    level_prev;
  logic [DW-1:0] deb_cnt [3];
  logic [2:0]    press;

  logic mode_press;
  logic up_press;
  logic down_press;
  logic up_level;
  logic down_level;
  logic both_held;
  logic repeat_held;
  logic active;

  state_t           state;
  state_t           state_next;
  rep_t             rep;
  rep_t             rep_next;
  logic             in_repeat;
  logic             in_repeat_next;
  logic [CNT_W-1:0] hold_cnt;
  logic [CNT_W-1:0] hold_next;
  logic [CNT_W-1:0] rep_cnt;
  logic [CNT_W-1:0] rep_cnt_next;
  logic [CNT_W-1:0] idle_cnt;
  logic [CNT_W-1:0] idle_next;
  logic             fire_up;
  logic             fire_down;

  logic       i_a_q;
  logic       i_h_q;
  logic       i_m_q;
  logic       d_h_q;
  logic       d_m_q;
  logic [1:0] sel_q;
  logic       editing_q;

  // Two-flop synchronizer, then accept a new level only after DEB_CYCLES
  // consecutive samples that disagree with the current debounced level
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1      <= '0;
      sync2      <= '0;
      level      <= '0;
      level_prev <= '0;
      for (int i = 0; i < 3; i++) deb_cnt[i] <= '0;
    end else begin
      sync1      <= {bus.btn_down, bus.btn_up, bus.btn_mode};
      sync2      <= sync1;
      level_prev <= level;
      for (int i = 0; i < 3; i++) begin
        if (sync2[i] == level[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == DEB_LAST) begin
          level[i]   <= sync2[i];
          deb_cnt[i] <= '0;
        end else begin
          deb_cnt[i] <= deb_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign press       = level & ~level_prev;
  assign mode_press  = press[0];
  assign up_press    = press[1];
  assign down_press  = press[2];
  assign up_level    = level[1];
  assign down_level  = level[2];
  assign both_held   = up_level & down_level;
  assign repeat_held = ((rep == REP_UP) & up_level) | ((rep == REP_DOWN) & down_level);
  assign active      = (|press) | (repeat_held & ~both_held);

  // Control state: field select, repeat tracking and idle timer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= RUN;
      rep       <= REP_NONE;
      in_repeat <= 1'b0;
      hold_cnt  <= '0;
      rep_cnt   <= '0;
      idle_cnt  <= '0;
    end else begin
      state     <= state_next;
      rep       <= rep_next;
      in_repeat <= in_repeat_next;
      hold_cnt  <= hold_next;
      rep_cnt   <= rep_cnt_next;
      idle_cnt  <= idle_next;
    end
  end

  // Next state and strobe requests; mode and timeout take priority over
  // up/down so a field change never coincides with a strobe
  always_comb begin
    state_next     = state;
    rep_next       = rep;
    in_repeat_next = in_repeat;
    hold_next      = hold_cnt;
    rep_cnt_next   = rep_cnt;
    idle_next      = idle_cnt;
    fire_up        = 1'b0;
    fire_down      = 1'b0;

    if (state == RUN) begin
      rep_next       = REP_NONE;
      in_repeat_next = 1'b0;
      hold_next      = '0;
      rep_cnt_next   = '0;
      idle_next      = '0;
      if (mode_press) state_next = SET_HOUR;
    end else if (mode_press) begin
      rep_next       = REP_NONE;
      in_repeat_next = 1'b0;
      hold_next      = '0;
      rep_cnt_next   = '0;
      idle_next      = '0;
      case (state)
        SET_HOUR: state_next = SET_MIN;
        SET_MIN:  state_next = SET_AP;
        default:  state_next = RUN;
      endcase
    end else if (!active && (idle_cnt >= IDLE_LAST)) begin
      state_next     = RUN;
      rep_next       = REP_NONE;
      in_repeat_next = 1'b0;
      hold_next      = '0;
      rep_cnt_next   = '0;
      idle_next      = '0;
    end else begin
      if (active) begin
        idle_next = '0;
      end else if (idle_cnt != CNT_MAX) begin
        idle_next = idle_cnt + 1'b1;
      end

      if (both_held) begin
        rep_next       = REP_NONE;
        in_repeat_next = 1'b0;
        hold_next      = '0;
        rep_cnt_next   = '0;
      end else if (up_press || down_press) begin
        fire_up        = up_press;
        fire_down      = down_press;
        in_repeat_next = 1'b0;
        rep_cnt_next   = '0;
        hold_next      = CNT_W'(1);
        if (state == SET_AP) begin
          rep_next = REP_NONE;
        end else begin
          rep_next = up_press ? REP_UP : REP_DOWN;
        end
      end else if (repeat_held) begin
        if (!in_repeat) begin
          if (hold_cnt >= HOLD_LAST) begin
            fire_up        = (rep == REP_UP);
            fire_down      = (rep == REP_DOWN);
            in_repeat_next = 1'b1;
            rep_cnt_next   = '0;
          end else begin
            hold_next = hold_cnt + 1'b1;
          end
        end else if (rep_cnt >= REP_LAST) begin
          fire_up      = (rep == REP_UP);
          fire_down    = (rep == REP_DOWN);
          rep_cnt_next = '0;
        end else begin
          rep_cnt_next = rep_cnt + 1'b1;
        end
      end else if (rep != REP_NONE) begin
        rep_next       = REP_NONE;
        in_repeat_next = 1'b0;
        hold_next      = '0;
        rep_cnt_next   = '0;
      end
    end
  end

  // Registered outputs: strobes routed to the selected field, sel/editing
  // updated together with the state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      i_a_q     <= 1'b0;
      i_h_q     <= 1'b0;
      i_m_q     <= 1'b0;
      d_h_q     <= 1'b0;
      d_m_q     <= 1'b0;
      sel_q     <= 2'd0;
      editing_q <= 1'b0;
    end else begin
      i_a_q     <= (state == SET_AP) & (fire_up | fire_down);
      i_h_q     <= (state == SET_HOUR) & fire_up;
      i_m_q     <= (state == SET_MIN) & fire_up;
      d_h_q     <= (state == SET_HOUR) & fire_down;
      d_m_q     <= (state == SET_MIN) & fire_down;
      sel_q     <= state_next;
      editing_q <= (state_next != RUN);
    end
  end

  assign bus.i_a     = i_a_q;
  assign bus.i_h     = i_h_q;
  assign bus.i_m     = i_m_q;
  assign bus.d_h     = d_h_q;
  assign bus.d_m     = d_m_q;
  assign bus.sel     = sel_q;
  assign bus.editing = editing_q;

endmodule

// File: tb/tb_time_set_ctrl.sv
// Bench for time_set_ctrl with short debounce/hold/repeat/timeout values.
// Table of button steps with expected sel/editing and strobe counts,
// plus hand-written sequences for repeat timing, timeout and async reset.
module tb_time_set_ctrl;

  localparam int DEB  = 4;
  localparam int HOLD = 20;
  localparam int REP  = 5;
  localparam int TMO  = 200;

  typedef struct {
    string      name;
    logic       mode;
    logic       up;
    logic       down;
    int         cycles;
    logic [1:0] e_sel;
    logic       e_edit;
    int         e_ia;
    int         e_ih;
    int         e_im;
    int         e_dh;
    int         e_dm;
  } vec_t;

  logic clk = 1'b0;
  logic rst;

  vec_t vecs[$];
  int   split_idx;
  int   n_vec  = 0;
  int   n_miss = 0;
  int   cyc    = 0;
  int   cnt[5];
  int   pulse_cyc[$];
  int   last_pulse = -100;
  int   spacing_err = 0;
  int   overlap_err = 0;

  always #5 clk = ~clk;

  time_set_ctrl_if bus();

  time_set_ctrl #(
    .DEB_CYCLES    (DEB),
    .HOLD_CYCLES   (HOLD),
    .REPEAT_CYCLES (REP),
    .TIMEOUT_CYCLES(TMO),
    .CNT_W         (16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Strobe vector: [4]=i_a [3]=i_h [2]=i_m [1]=d_h [0]=d_m
  function automatic logic [4:0] strobes();
    return {bus.i_a, bus.i_h, bus.i_m, bus.d_h, bus.d_m};
  endfunction

  task automatic check_output(input string name, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_miss++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  task automatic clear_counts();
    for (int i = 0; i < 5; i++) cnt[i] = 0;
  endtask

  // One clock: sample on the falling edge, tally strobes and spacing
  task automatic sample_outputs();
    logic [4:0] s;
    @(negedge clk);
    cyc++;
    s = strobes();
    for (int i = 0; i < 5; i++) if (s[i]) cnt[i]++;
    if ($countones(s) > 1) overlap_err++;
    if (s != 5'd0) begin
      if (cyc - last_pulse < 3) spacing_err++;
      last_pulse = cyc;
      pulse_cyc.push_back(cyc);
    end
  endtask

  task automatic apply_stimulus(input logic m, input logic u, input logic d, input int n);
    bus.btn_mode = m;
    bus.btn_up   = u;
    bus.btn_down = d;
    repeat (n) sample_outputs();
  endtask

  function automatic void add_vec(input string nm, input logic m, input logic u, input logic d,
                                  input int n, input logic [1:0] s, input logic e,
                                  input int ia, input int ih, input int im, input int dh, input int dm);
    vec_t v;
    v.name = nm; v.mode = m; v.up = u; v.down = d; v.cycles = n;
    v.e_sel = s; v.e_edit = e;
    v.e_ia = ia; v.e_ih = ih; v.e_im = im; v.e_dh = dh; v.e_dm = dm;
    vecs.push_back(v);
  endfunction

  task automatic run_vectors(input int first, input int last);
    for (int i = first; i <= last; i++) begin
      clear_counts();
      apply_stimulus(vecs[i].mode, vecs[i].up, vecs[i].down, vecs[i].cycles);
      check_output({vecs[i].name, " sel"},     int'(bus.sel),     int'(vecs[i].e_sel));
      check_output({vecs[i].name, " editing"}, int'(bus.editing), int'(vecs[i].e_edit));
      check_output({vecs[i].name, " i_a"}, cnt[4], vecs[i].e_ia);
      check_output({vecs[i].name, " i_h"}, cnt[3], vecs[i].e_ih);
      check_output({vecs[i].name, " i_m"}, cnt[2], vecs[i].e_im);
      check_output({vecs[i].name, " d_h"}, cnt[1], vecs[i].e_dh);
      check_output({vecs[i].name, " d_m"}, cnt[0], vecs[i].e_dm);
    end
  endtask

  initial begin
    int start;
    int hold_cnt_seen;
    int exp_off[6];
    bit done;

    exp_off = '{0, 19, 24, 29, 34, 39};

    //        name              m  u  d   n  sel ed  ia ih im dh dm
    add_vec("mode glitch",     1, 0, 0,   2, 0, 0,  0, 0, 0, 0, 0);
    add_vec("idle run",        0, 0, 0,  10, 0, 0,  0, 0, 0, 0, 0);
    add_vec("up in run",       0, 1, 0,  10, 0, 0,  0, 0, 0, 0, 0);
    add_vec("rel run a",       0, 0, 0,  12, 0, 0,  0, 0, 0, 0, 0);
    add_vec("down in run",     0, 0, 1,  10, 0, 0,  0, 0, 0, 0, 0);
    add_vec("rel run b",       0, 0, 0,  12, 0, 0,  0, 0, 0, 0, 0);
    add_vec("mode to hour",    1, 0, 0,  10, 1, 1,  0, 0, 0, 0, 0);
    add_vec("rel mode a",      0, 0, 0,  10, 1, 1,  0, 0, 0, 0, 0);
    add_vec("up hour",         0, 1, 0,  10, 1, 1,  0, 1, 0, 0, 0);
    add_vec("rel up hour",     0, 0, 0,  12, 1, 1,  0, 0, 0, 0, 0);
    add_vec("down hour",       0, 0, 1,  10, 1, 1,  0, 0, 0, 1, 0);
    add_vec("rel down hour",   0, 0, 0,  12, 1, 1,  0, 0, 0, 0, 0);
    add_vec("mode to min",     1, 0, 0,  10, 2, 1,  0, 0, 0, 0, 0);
    add_vec("rel mode b",      0, 0, 0,  10, 2, 1,  0, 0, 0, 0, 0);
    split_idx = vecs.size();
    add_vec("mode to ap",      1, 0, 0,  10, 3, 1,  0, 0, 0, 0, 0);
    add_vec("rel mode c",      0, 0, 0,  10, 3, 1,  0, 0, 0, 0, 0);
    add_vec("down hold ap",    0, 0, 1, 100, 3, 1,  1, 0, 0, 0, 0);
    add_vec("rel down ap",     0, 0, 0,  12, 3, 1,  0, 0, 0, 0, 0);
    add_vec("up ap",           0, 1, 0,  10, 3, 1,  1, 0, 0, 0, 0);
    add_vec("rel up ap",       0, 0, 0,  12, 3, 1,  0, 0, 0, 0, 0);
    add_vec("mode to run",     1, 0, 0,  10, 0, 0,  0, 0, 0, 0, 0);
    add_vec("rel mode d",      0, 0, 0,  10, 0, 0,  0, 0, 0, 0, 0);
    add_vec("mode to hour 2",  1, 0, 0,  10, 1, 1,  0, 0, 0, 0, 0);
    add_vec("rel mode e",      0, 0, 0,  10, 1, 1,  0, 0, 0, 0, 0);
    add_vec("up press",        0, 1, 0,  10, 1, 1,  0, 1, 0, 0, 0);
    add_vec("up and down",     0, 1, 1,  30, 1, 1,  0, 0, 0, 0, 0);
    add_vec("up after down",   0, 1, 0,  40, 1, 1,  0, 0, 0, 0, 0);
    add_vec("rel both",        0, 0, 0,  12, 1, 1,  0, 0, 0, 0, 0);
    add_vec("fresh up",        0, 1, 0,  10, 1, 1,  0, 1, 0, 0, 0);
    add_vec("mode over up",    1, 1, 0,  10, 2, 1,  0, 0, 0, 0, 0);
    add_vec("up held in min",  0, 1, 0,  30, 2, 1,  0, 0, 0, 0, 0);
    add_vec("rel all",         0, 0, 0,  12, 2, 1,  0, 0, 0, 0, 0);
    add_vec("min to ap",       1, 0, 0,  10, 3, 1,  0, 0, 0, 0, 0);
    add_vec("rel mode f",      0, 0, 0,  10, 3, 1,  0, 0, 0, 0, 0);
    add_vec("ap to run",       1, 0, 0,  10, 0, 0,  0, 0, 0, 0, 0);
    add_vec("rel mode g",      0, 0, 0,  10, 0, 0,  0, 0, 0, 0, 0);
    add_vec("run to hour",     1, 0, 0,  10, 1, 1,  0, 0, 0, 0, 0);
    add_vec("rel mode h",      0, 0, 0,  10, 1, 1,  0, 0, 0, 0, 0);

    // Reset state
    rst = 1'b1;
    bus.btn_mode = 1'b0;
    bus.btn_up   = 1'b0;
    bus.btn_down = 1'b0;
    repeat (3) @(negedge clk);
    check_output("reset sel",     int'(bus.sel),     0);
    check_output("reset editing", int'(bus.editing), 0);
    check_output("reset strobes", int'(strobes()),   0);
    rst = 1'b0;

    run_vectors(0, split_idx - 1);

    // Auto-repeat in SET_MIN: first strobe 7 samples after the raw press
    // (2 sync + DEB debounce + edge + strobe register), then at offsets
    // HOLD-1 and every REP after that, relative to the first strobe
    pulse_cyc.delete();
    clear_counts();
    start = cyc;
    apply_stimulus(1'b0, 1'b1, 1'b0, 42);
    apply_stimulus(1'b0, 1'b0, 1'b0, 20);
    check_output("repeat i_m count", cnt[2], 6);
    check_output("repeat other strobes", cnt[4] + cnt[3] + cnt[1] + cnt[0], 0);
    check_output("repeat pulse count", pulse_cyc.size(), 6);
    if (pulse_cyc.size() > 0) begin
      check_output("repeat first latency", pulse_cyc[0] - start, 7);
      for (int i = 1; i < 6; i++) begin
        if (i < pulse_cyc.size())
          check_output($sformatf("repeat offset %0d", i), pulse_cyc[i] - pulse_cyc[0], exp_off[i]);
      end
    end
    check_output("repeat sel", int'(bus.sel), 2);

    run_vectors(split_idx, vecs.size() - 1);

    // Timeout: SET_MIN entered by a mode edge and then left idle must
    // show sel=2 for exactly TMO sampled cycles
    clear_counts();
    bus.btn_mode = 1'b1;
    done = 1'b0;
    for (int i = 0; i < 30 && !done; i++) begin
      sample_outputs();
      if (bus.sel == 2'd2) done = 1'b1;
    end
    check_output("timeout entry reached", int'(done), 1);
    bus.btn_mode = 1'b0;
    hold_cnt_seen = 1;
    done = 1'b0;
    for (int i = 0; i < 2 * TMO && !done; i++) begin
      sample_outputs();
      if (bus.sel == 2'd2) hold_cnt_seen++;
      else done = 1'b1;
    end
    check_output("timeout cycles in SET_MIN", hold_cnt_seen, TMO);
    check_output("timeout sel", int'(bus.sel), 0);
    check_output("timeout editing", int'(bus.editing), 0);
    check_output("timeout strobes", cnt[4] + cnt[3] + cnt[2] + cnt[1] + cnt[0], 0);

    // Async reset while a repeat strobe is high
    apply_stimulus(1'b1, 1'b0, 1'b0, 10);
    apply_stimulus(1'b0, 1'b0, 1'b0, 10);
    check_output("pre-reset sel", int'(bus.sel), 1);
    clear_counts();
    bus.btn_up = 1'b1;
    done = 1'b0;
    for (int i = 0; i < 80 && !done; i++) begin
      sample_outputs();
      if (cnt[3] == 2 && bus.i_h) done = 1'b1;
    end
    check_output("reset seq reached repeat", int'(done), 1);
    rst = 1'b1;
    #1;
    check_output("async reset strobes", int'(strobes()),   0);
    check_output("async reset sel",     int'(bus.sel),     0);
    check_output("async reset editing", int'(bus.editing), 0);
    bus.btn_up = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    apply_stimulus(1'b0, 1'b0, 1'b0, 5);
    check_output("post-reset sel", int'(bus.sel), 0);

    check_output("strobe overlap", overlap_err, 0);
    check_output("strobe spacing", spacing_err, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
